// File: rtl/rgb_frame_fetch.sv
// rgb_frame_fetch: reads the packed RGB frame from SRAM and streams 24-bit pixels with raster coordinates
module rgb_frame_fetch #(
    parameter logic [17:0] RGB_BASE    = 18'd146944,
    parameter int          FRAME_WORDS = 115200,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        CLOCK_50_I,
    input  logic        Reset,
    input  logic        start,
    input  logic [15:0] SRAM_read_data,
    output logic [17:0] address,
    output logic        write_en_n,
    output logic [7:0]  pixel_R,
    output logic [7:0]  pixel_G,
    output logic [7:0]  pixel_B,
    output logic [8:0]  pixel_x,
    output logic [7:0]  pixel_y,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic        busy,
    output logic        frame_done
);
    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [16:0] FW     = 17'(FRAME_WORDS);
    localparam logic [7:0]  LAST_Y = 8'(FRAME_WORDS * 2 / 3 / 320 - 1);
    localparam logic [AW:0] DEPTH  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t        state, state_n;
    logic [16:0]   issue_cnt;
    logic [2:0]    tag;
    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   fifo_count, in_flight, pop;
    logic          go, issue, push, load, last, phase;
    logic [15:0]   head, nxt;
    logic [8:0]    nx;
    logic [7:0]    ny;

    assign write_en_n = 1'b1;
    assign busy       = state == FETCH || state == DRAIN;
    assign frame_done = state == DONE;

    // next state, read credit check and pixel load decision
    always_comb begin
        go        = state == IDLE && start;
        in_flight = (AW + 1)'(tag[0]) + (AW + 1)'(tag[1]) + (AW + 1)'(tag[2]);
        issue     = state == FETCH && issue_cnt < FW && fifo_count + in_flight < DEPTH;
        push      = tag[2];
        head      = fifo_mem[rd_ptr];
        nxt       = fifo_mem[rd_ptr + 1'b1];
        load      = busy && (!pixel_valid || pixel_ready) && fifo_count >= (AW + 1)'(2);
        pop       = load ? (phase ? (AW + 1)'(2) : (AW + 1)'(1)) : '0;
        last      = pixel_valid && pixel_ready && pixel_x == 9'd319 && pixel_y == LAST_Y;
        state_n   = state == IDLE ? (start ? FETCH : IDLE) :
                    state == DONE ? IDLE :
                    last ? DONE :
                    (state == FETCH && issue_cnt == FW) ? DRAIN : state;
    end

    // state register
    always_ff @(posedge CLOCK_50_I or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    // address counter and three-stage in-flight tag pipe matching SRAM latency
    always_ff @(posedge CLOCK_50_I or posedge Reset) begin
        if (Reset) begin
            address   <= '0;
            issue_cnt <= '0;
            tag       <= '0;
        end else begin
            tag <= {tag[1:0], go | issue};
            if (go) begin
                address   <= RGB_BASE;
                issue_cnt <= 17'd1;
            end else if (issue) begin
                address   <= address + 18'd1;
                issue_cnt <= issue_cnt + 17'd1;
            end
        end
    end

    // word FIFO storage; stale entries are harmless since tags are cleared on reset
    always_ff @(posedge CLOCK_50_I) begin
        if (push) fifo_mem[wr_ptr] <= SRAM_read_data;
    end

    // FIFO pointers and occupancy; even loads pop one word so w1 stays at the head
    always_ff @(posedge CLOCK_50_I or posedge Reset) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + pop[AW-1:0];
            fifo_count <= fifo_count + (AW + 1)'(push) - pop;
        end
    end

    // output pixel register, unpack phase and raster coordinates
    always_ff @(posedge CLOCK_50_I or posedge Reset) begin
        if (Reset) begin
            {pixel_R, pixel_G, pixel_B} <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_valid <= 1'b0;
            phase       <= 1'b0;
            nx          <= '0;
            ny          <= '0;
        end else begin
            pixel_valid <= load | (pixel_valid & ~pixel_ready);
            if (go) begin
                phase   <= 1'b0;
                nx      <= '0;
                ny      <= '0;
                pixel_x <= '0;
                pixel_y <= '0;
            end else if (load) begin
                {pixel_R, pixel_G, pixel_B} <= phase ? {head[7:0], nxt} : {head, nxt[15:8]};
                pixel_x <= nx;
                pixel_y <= ny;
                nx      <= nx == 9'd319 ? 9'd0 : nx + 9'd1;
                ny      <= nx == 9'd319 ? ny + 8'd1 : ny;
                phase   <= ~phase;
            end
        end
    end
endmodule

// File: tb/tb_rgb_frame_fetch.sv
// tb_rgb_frame_fetch: directed bench for rgb_frame_fetch on a reduced 4-row frame ending at the top SRAM word
module tb_rgb_frame_fetch;
    localparam logic [17:0] BASE = 18'd260224;
    localparam int          FW   = 1920;
    localparam int          NPIX = 1280;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        start = 1'b0;
    logic        pixel_ready = 1'b0;
    logic [15:0] SRAM_read_data;
    logic [17:0] address;
    logic        write_en_n, pixel_valid, busy, frame_done;
    logic [7:0]  pixel_R, pixel_G, pixel_B, pixel_y;
    logic [8:0]  pixel_x;

    int checks = 0, failures = 0;
    int pix_n, issued, done_cnt;
    bit mon_en = 1'b0, st_prev, fin_prev, rnd = 1'b0, any;
    logic [17:0] prev_addr = '0, r1 = '0, r2 = '0;
    logic [40:0] prev_px;
    logic [16:0] last_xy;

    rgb_frame_fetch #(.RGB_BASE(BASE), .FRAME_WORDS(FW), .FIFO_DEPTH(8)) dut (
        .CLOCK_50_I(clk), .Reset(Reset), .start(start), .SRAM_read_data(SRAM_read_data),
        .address(address), .write_en_n(write_en_n), .pixel_R(pixel_R), .pixel_G(pixel_G),
        .pixel_B(pixel_B), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [31:0] a);
        logic [31:0] o = a - 32'(BASE);
        if (o == 0) return 16'h1122;
        if (o == 1) return 16'h3344;
        if (o == 2) return 16'h5566;
        return 16'((a * 32'd40503) ^ (a >> 2));
    endfunction

    function automatic logic [40:0] gold(input int n);
        logic [31:0] a = 32'(BASE) + 32'(3 * (n / 2));
        logic [15:0] w0 = word(a), w1 = word(a + 1), w2 = word(a + 2);
        return {9'(n % 320), 8'(n / 320), (n % 2) ? {w1[7:0], w2} : {w0, w1[15:8]}};
    endfunction

    // SRAM: word for the address registered at edge k is presented for sampling at edge k+3
    always @(posedge clk) begin
        r1 <= address;
        r2 <= r1;
    end
    assign SRAM_read_data = word(32'(r2));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: address order, pixel data, stall stability, done pulse timing
    always @(negedge clk) begin
        if (mon_en) begin
            if (st_prev) chk("hold", {pixel_valid, pixel_x, pixel_y, pixel_R, pixel_G, pixel_B}, {1'b1, prev_px});
            if (fin_prev) begin
                chk("done_pulse", frame_done, 1);
                chk("busy_fall", busy, 0);
            end
            if (busy && address != prev_addr) begin
                chk("addr_seq", address, 32'(BASE) + 32'(issued));
                issued++;
            end
            if (frame_done) done_cnt++;
            if (busy) chk("fifo_bound", dut.fifo_count <= 4'd8, 1);
            fin_prev = 1'b0;
            if (pixel_valid && pixel_ready) begin
                chk("pix", {pixel_x, pixel_y, pixel_R, pixel_G, pixel_B}, gold(pix_n));
                last_xy = {pixel_x, pixel_y};
                fin_prev = pix_n == NPIX - 1;
                pix_n++;
            end
            st_prev = pixel_valid && !pixel_ready;
            prev_px = {pixel_x, pixel_y, pixel_R, pixel_G, pixel_B};
        end
        prev_addr = address;
    end

    task automatic begin_frame();
        issued = 0; pix_n = 0; done_cnt = 0; st_prev = 0; fin_prev = 0; mon_en = 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic finish_frame(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            @(posedge clk); #1;
            if (rnd) pixel_ready = 1'($urandom_range(0, 1));
        end
        pixel_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("done_cnt", done_cnt, 1);
        chk("pix_cnt", pix_n, NPIX);
        chk("addr_cnt", issued, FW);
        chk("last_addr", address, 18'd262143);
        chk("last_xy", last_xy, {9'd319, 8'd3});
        chk("end_busy", busy, 0);
        chk("end_valid", pixel_valid, 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk(tag, {address, write_en_n, pixel_R, pixel_G, pixel_B, pixel_x, pixel_y, pixel_valid, busy, frame_done},
            {18'd0, 1'b1, 24'd0, 9'd0, 8'd0, 1'b0, 1'b0, 1'b0});
    endtask

    initial begin
        #2 Reset = 1'b1;
        #1 check_reset_values("reset_vals");
        repeat (3) @(posedge clk);
        #1 Reset = 1'b0;
        any = 0;
        repeat (100) begin
            @(posedge clk); #1;
            any |= pixel_valid | busy;
        end
        chk("idle_quiet", any, 0);
        chk("idle_addr", address, 0);

        pixel_ready = 1'b1;
        begin_frame();
        chk("start_busy", busy, 1);
        chk("start_addr", address, BASE);
        repeat (4) @(posedge clk);
        #1 chk("valid_e4", pixel_valid, 0);
        @(posedge clk); #1;
        chk("first_pix", {pixel_valid, pixel_x, pixel_y, pixel_R, pixel_G, pixel_B}, {1'b1, 17'd0, 24'h112233});
        @(posedge clk); #1;
        chk("second_pix", {pixel_valid, pixel_x, pixel_y, pixel_R, pixel_G, pixel_B}, {1'b1, 9'd1, 8'd0, 24'h445566});
        finish_frame(5000);
        chk("wen_n", write_en_n, 1);

        rnd = 1'b1;
        begin_frame();
        finish_frame(20000);
        rnd = 1'b0;

        begin_frame();
        for (int i = 0; i < 5000 && pix_n < 1000; i++) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        finish_frame(5000);
        repeat (20) @(posedge clk);
        #1 chk("no_restart", {busy, address}, {1'b0, 18'd262143});

        begin_frame();
        for (int i = 0; i < 5000 && pix_n < 700; i++) begin @(posedge clk); #1; end
        #2 Reset = 1'b1;
        #1 check_reset_values("midreset_vals");
        mon_en = 0;
        chk("midreset_fifo", dut.fifo_count, 0);
        repeat (3) @(posedge clk);
        #1 Reset = 1'b0;
        any = 0;
        repeat (10) begin
            @(posedge clk); #1;
            any |= pixel_valid | busy | (address != 0);
        end
        chk("post_reset_quiet", any, 0);
        begin_frame();
        chk("restart_addr", address, BASE);
        finish_frame(5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rgb_frame_fetch.md
# rgb_frame_fetch

Downstream consumer of the colour-space-conversion stage. Reads the packed RGB frame (320x240) that stage writes to SRAM starting at word 146944, unpacks the 3-words-per-2-pixels format into one 24-bit pixel per handshake, and presents pixels with raster coordinates to the display/readout stage over a valid/ready interface. Read-only SRAM master; owns the SRAM address bus only while busy.

## Interface
- RGB_BASE, 18'd146944, first SRAM word of the RGB frame
- FRAME_WORDS, 115200, RGB words per frame (320*240*3/2)
- FIFO_DEPTH, 8, word FIFO entries (power of two, >= 4)
- CLOCK_50_I  in  1  single clock, all logic on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  begin one frame fetch; sampled only in IDLE
- SRAM_read_data  in  16  SRAM read word
- address  out  18  SRAM word address (registered)
- write_en_n  out  1  SRAM write enable, active low; held 1 (never writes)
- pixel_R, pixel_G, pixel_B  out  8 each  current pixel
- pixel_x  out  9  column 0..319 of current pixel
- pixel_y  out  8  row 0..239 of current pixel
- pixel_valid  out  1  pixel outputs hold a valid pixel
- pixel_ready  in  1  consumer accepts pixel when pixel_valid & pixel_ready
- busy  out  1  high from start acceptance until frame_done
- frame_done  out  1  one-cycle pulse after last pixel accepted

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: busy=0. start=1 -> FETCH; same edge drives address<=RGB_BASE, issue_cnt<=1, marks one read in flight.
- FETCH: each cycle issues next address (address+1) iff issue_cnt < FRAME_WORDS and (fifo_count + in_flight) < FIFO_DEPTH; otherwise address holds. issue_cnt == FRAME_WORDS -> DRAIN.
- DRAIN: no reads issued; continues unpacking until pixel (319,239) accepted -> DONE.
- DONE: frame_done=1 for exactly one cycle, busy<=0 -> IDLE.
- start while busy: ignored.
- SRAM read latency: data for the address registered at edge k is sampled at edge k+3. In-flight tracking: 3-bit issue-tag shift register; tag at stage 3 writes SRAM_read_data into the FIFO.
- Unpacking, words w0,w1,w2 in order: even pixel = {R,G,B} = {w0[15:8], w0[7:0], w1[15:8]}; odd pixel = {w1[7:0], w2[15:8], w2[7:0]}.
- Phase bit (0 = even). Output register loads when (pixel_valid=0 or accepted this cycle) and fifo_count >= 2. Even load pops 1 word (w1 stays at head); odd load pops 2 words. Phase toggles per load.
- pixel_x/pixel_y advance per load: x wraps 319->0 with y+1; loaded with (0,0) at start.
- Pixel outputs and coordinates hold stable while pixel_valid=1 and pixel_ready=0.
- Simultaneous FIFO push and pop in one cycle are both honoured; FIFO never overflows by construction of the credit check.

## Timing
- Reset values: address=0, write_en_n=1, pixel_R/G/B=0, pixel_x=0, pixel_y=0, pixel_valid=0, busy=0, frame_done=0, state=IDLE, FIFO empty, in-flight tags cleared.
- Reset mid-frame: all of the above on assertion, no further reads; any returning SRAM data discarded; new start required after release.
- First pixel: start sampled at edge 0; w0 into FIFO at edge 3, w1 at edge 4; pixel_valid=1 after edge 5.
- Sustained throughput with pixel_ready=1: one SRAM read per cycle, 2 pixels per 3 cycles; full frame ~115205 cycles plus DONE.
- Address wrap: last word = RGB_BASE+FRAME_WORDS-1 = 262143 (2^18-1); the address counter is never incremented past it (no wrap to 0 issued).
- frame_done asserts the cycle after the final handshake; busy falls on that same edge.

## Test plan
- Reset then idle: all outputs at reset values; start=0 for 100 cycles -> address=0, no pixel_valid.
- First pixels: SRAM model 0x1122,0x3344,0x5566 at 146944..146946, start pulse, ready=1 -> pixel_valid after edge 5 with (R,G,B)=(11,22,33) at (0,0), next (44,55,66) at (1,0).
- Backpressure: ready toggled randomly 50% -> every pixel matches golden unpack, no duplicate/skip, outputs stable while stalled, fifo never exceeds 8.
- Full frame ready=1: addresses 146944..262143 each issued once in order; 76800 handshakes; last coordinate (319,239); frame_done single pulse; busy=0 after.
- start during busy at pixel 1000 -> ignored, frame completes unchanged, no restart.
- Reset asserted at pixel 5000 with reads in flight -> immediate reset values; new start fetches from 146944 and first pixel is (0,0) with correct data.
